// File: rtl/buffer_multi_bank_acc.sv
// rtl/buffer_multi_bank_acc.sv - N-way rotating output buffer with optional in-place accumulation.
// The write bank sits at wptr; the oldest completed frame (wptr+1) is presented on the output.
module buffer_multi_bank_acc #(
   parameter int IWID  = 8,
   parameter int OWID  = IWID + 4,
   parameter int NBANK = 2,
   parameter int SAT   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iValid,
   input  logic            iAcc,
   input  logic            iSwap,
   input  logic [IWID-1:0] iData,
   output logic [OWID-1:0] oData,
   output logic            oValid,
   output logic            oOvf
);

   localparam int PW = (NBANK > 1) ? $clog2(NBANK) : 1;
   localparam logic [PW-1:0] LAST = PW'(NBANK - 1);

   logic [OWID-1:0] bank_q [NBANK];
   logic [OWID-1:0] bank_d [NBANK];
   logic [NBANK-1:0] ovf_q, ovf_d;
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   fill_q, fill_d;
   logic [PW-1:0]   rptr;
   logic [OWID:0]   sum;

   // The bank after the write bank is both the read bank and the next write bank.
   always_comb begin
      rptr = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
   end

   always_comb begin
      bank_d = bank_q;
      ovf_d  = ovf_q;
      wptr_d = wptr_q;
      fill_d = fill_q;
      sum    = {1'b0, bank_q[wptr_q]} + (OWID+1)'(iData);

      if (iValid) begin
         if (iAcc) begin
            if (sum[OWID]) begin
               ovf_d[wptr_q] = 1'b1;
               if (SAT != 0) begin
                  bank_d[wptr_q] = '1;
               end else begin
                  bank_d[wptr_q] = sum[OWID-1:0];
               end
            end else begin
               bank_d[wptr_q] = sum[OWID-1:0];
            end
         end else begin
            bank_d[wptr_q] = OWID'(iData);
         end
      end

      // rptr never equals wptr, so clearing it cannot collide with the closing write.
      if (iSwap) begin
         bank_d[rptr] = '0;
         ovf_d[rptr]  = 1'b0;
         wptr_d       = rptr;
         fill_d       = (fill_q == LAST) ? fill_q : fill_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NBANK; i++) begin
            bank_q[i] <= '0;
         end
         ovf_q  <= '0;
         wptr_q <= '0;
         fill_q <= '0;
      end else begin
         for (int i = 0; i < NBANK; i++) begin
            bank_q[i] <= bank_d[i];
         end
         ovf_q  <= ovf_d;
         wptr_q <= wptr_d;
         fill_q <= fill_d;
      end
   end

   always_comb begin
      oData  = bank_q[rptr];
      oOvf   = ovf_q[rptr];
      oValid = (fill_q == LAST);
   end

endmodule

// File: tb/tb_buffer_multi_bank_acc.sv
// tb/tb_buffer_multi_bank_acc.sv - three configurations driven in lockstep against a frame-history model.
// dut0: OWID=8 NBANK=4 SAT=1; dut1: OWID=8 NBANK=2 SAT=0; dut2: OWID=12 NBANK=2 SAT=1.
module tb_buffer_multi_bank_acc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       iv = 1'b0, ia = 1'b0, is = 1'b0;
   logic [7:0] id = '0;
   logic [7:0]  od0, od1;
   logic [11:0] od2;
   logic ov0, ov1, ov2, of0, of1, of2;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   buffer_multi_bank_acc #(.IWID(8), .OWID(8), .NBANK(4), .SAT(1)) dut0 (
      .clk(clk), .rst(rst), .iValid(iv), .iAcc(ia), .iSwap(is), .iData(id),
      .oData(od0), .oValid(ov0), .oOvf(of0));
   buffer_multi_bank_acc #(.IWID(8), .OWID(8), .NBANK(2), .SAT(0)) dut1 (
      .clk(clk), .rst(rst), .iValid(iv), .iAcc(ia), .iSwap(is), .iData(id),
      .oData(od1), .oValid(ov1), .oOvf(of1));
   buffer_multi_bank_acc #(.IWID(8), .OWID(12), .NBANK(2), .SAT(1)) dut2 (
      .clk(clk), .rst(rst), .iValid(iv), .iAcc(ia), .iSwap(is), .iData(id),
      .oData(od2), .oValid(ov2), .oOvf(of2));

   function automatic int nb(int k);
      return (k == 0) ? 4 : 2;
   endfunction
   function automatic int ow(int k);
      return (k == 2) ? 12 : 8;
   endfunction
   function automatic bit sat(int k);
      return (k != 1);
   endfunction

   // Model: the open frame as a plain integer, plus the most recent completed frames (index 0 newest).
   int cur [3];
   bit cov [3];
   int hv  [3][4];
   bit ho  [3][4];
   int cnt [3];

   task automatic model_step(bit r, bit v, bit a, bit s, int d);
      int sum;
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            cur[k] = 0; cov[k] = 1'b0; cnt[k] = 0;
            for (int j = 0; j < 4; j++) begin
               hv[k][j] = 0; ho[k][j] = 1'b0;
            end
         end else begin
            if (v) begin
               if (a) begin
                  sum = cur[k] + d;
                  if (sum >= (1 << ow(k))) begin
                     cov[k] = 1'b1;
                     cur[k] = sat(k) ? (1 << ow(k)) - 1 : sum - (1 << ow(k));
                  end else begin
                     cur[k] = sum;
                  end
               end else begin
                  cur[k] = d;
               end
            end
            if (s) begin
               for (int j = 3; j > 0; j--) begin
                  hv[k][j] = hv[k][j-1]; ho[k][j] = ho[k][j-1];
               end
               hv[k][0] = cur[k]; ho[k][0] = cov[k];
               cur[k] = 0; cov[k] = 1'b0;
               if (cnt[k] < nb(k) - 1) cnt[k]++;
            end
         end
      end
   endtask

   function automatic bit exp_v(int k);
      return cnt[k] >= nb(k) - 1;
   endfunction
   function automatic int exp_d(int k);
      return exp_v(k) ? hv[k][nb(k)-2] : 0;
   endfunction
   function automatic bit exp_o(int k);
      return exp_v(k) ? ho[k][nb(k)-2] : 1'b0;
   endfunction

   task automatic chk(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step(bit r, bit v, bit a, bit s, int d);
      rst = r; iv = v; ia = a; is = s; id = d[7:0];
      @(posedge clk);
      model_step(r, v, a, s, d);
      #1;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cmp_d0", int'(od0), exp_d(0)); chk("cmp_v0", int'(ov0), int'(exp_v(0))); chk("cmp_o0", int'(of0), int'(exp_o(0)));
         chk("cmp_d1", int'(od1), exp_d(1)); chk("cmp_v1", int'(ov1), int'(exp_v(1))); chk("cmp_o1", int'(of1), int'(exp_o(1)));
         chk("cmp_d2", int'(od2), exp_d(2)); chk("cmp_v2", int'(ov2), int'(exp_v(2))); chk("cmp_o2", int'(of2), int'(exp_o(2)));
      end
   end

   initial begin
      step(1, 1, 0, 0, 8'hFF);
      step(1, 1, 0, 0, 8'hFF);
      cmp_en = 1'b1;
      chk("rst_d0", int'(od0), 0); chk("rst_v0", int'(ov0), 0); chk("rst_o0", int'(of0), 0);
      chk("rst_d2", int'(od2), 0); chk("rst_v2", int'(ov2), 0); chk("rst_o2", int'(of2), 0);
      step(0, 0, 0, 1, 0);
      chk("rst_nowrite_d2", int'(od2), 0); chk("rst_nowrite_v2", int'(ov2), 1);

      // ping-pong
      step(0, 1, 0, 0, 8'h12);
      step(0, 0, 0, 1, 0);
      chk("pp_first_d2", int'(od2), 'h12); chk("pp_first_v2", int'(ov2), 1);
      step(0, 1, 0, 0, 8'h34);
      chk("pp_hold_d2", int'(od2), 'h12);
      step(0, 0, 0, 1, 0);
      chk("pp_second_d2", int'(od2), 'h34);

      // accumulate with swap on last write
      step(0, 1, 1, 0, 10);
      step(0, 1, 1, 0, 20);
      step(0, 1, 1, 1, 30);
      chk("acc_d2", int'(od2), 60); chk("acc_o2", int'(of2), 0);
      chk("acc_model", exp_d(2), 60);

      // saturation / wrap
      step(1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 200);
      step(0, 1, 1, 1, 100);
      chk("wrap_d1", int'(od1), 44); chk("wrap_o1", int'(of1), 1);
      chk("wrap_model", exp_d(1), 44);
      chk("wide_d2", int'(od2), 300); chk("wide_o2", int'(of2), 0);
      step(0, 0, 0, 1, 0);
      chk("wrap_next_d1", int'(od1), 0); chk("wrap_next_o1", int'(of1), 0);
      step(0, 0, 0, 1, 0);
      chk("sat_d0", int'(od0), 255); chk("sat_o0", int'(of0), 1); chk("sat_v0", int'(ov0), 1);
      chk("sat_model", exp_d(0), 255);
      step(0, 0, 0, 1, 0);
      chk("sat_next_d0", int'(od0), 0); chk("sat_next_o0", int'(of0), 0);

      // depth with NBANK=4
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 1);
      step(0, 1, 0, 1, 2);
      chk("depth_nv0", int'(ov0), 0);
      step(0, 1, 0, 1, 3);
      chk("depth_v0", int'(ov0), 1); chk("depth_a_d0", int'(od0), 1);
      step(0, 1, 0, 1, 4);
      chk("depth_b_d0", int'(od0), 2);

      // write coinciding with swap, empty frames, mid-frame reset
      step(0, 1, 0, 0, 7);
      step(0, 1, 1, 1, 5);
      chk("closing_acc_d2", int'(od2), 12);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("empty_d2", int'(od2), 0);
      step(0, 1, 0, 0, 9);
      step(1, 1, 1, 1, 9);
      chk("midrst_d0", int'(od0), 0); chk("midrst_v0", int'(ov0), 0);
      chk("midrst_v1", int'(ov1), 0); chk("midrst_d2", int'(od2), 0);

      // random traffic
      repeat (3000) begin
         step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
              int'($urandom_range(0, 255)));
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
